bf_program_loader: RTL and testbench
====================================

// Module: bf_program_loader
// PURPOSE
//  Upstream stage of program memory (pmemory). Accepts ASCII Brainfuck source one
//  character at a time and discards non-command characters. It encodes each of the
//  8 command characters to a 4-bit opcode and writes them to consecutive pmemory
//  addresses from 0. At end of input it appends HALT, checks bracket balance and
//  pulses control's inputDone path. Drives PM data/wren/address while loading.
// PARAMETERS
//  ADDR_W   16     pmemory address width
//  DEPTH    65536  pmemory words; last usable command slot is DEPTH-2 (one slot for HALT)
//  NEST_W   8      bracket-depth counter width; max nesting 2**NEST_W-1
// PORTS
//  clock        in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  char_in      in   8       ASCII source character
//  char_valid   in   1       char_in valid; transfer when char_valid & char_ready
//  char_ready   out  1       loader can accept a character (state LOAD)
//  end_in       in   1       end-of-source strobe (one cycle)
//  restart      in   1       from DONE/ERROR: clear and return to LOAD
//  pm_addr      out  ADDR_W  pmemory write address
//  pm_data      out  4       opcode to pmemory
//  pm_wren      out  1       pmemory write enable
//  input_done   out  1       program loaded and valid; level, to control.inputDone
//  prog_len     out  ADDR_W  number of commands stored (HALT excluded)
//  err_overflow out  1       source exceeded DEPTH-1 commands
//  err_bracket  out  1       unmatched ']', nesting > max, or open '[' at end
// BEHAVIOUR
//  Reset: state LOAD; pm_addr=0, pm_data=0, pm_wren=0, input_done=0, prog_len=0,
//   err_*=0, depth=0. char_ready=1 from the first clock after reset release.
//  Opcodes: HALT=0 '>'=1 '<'=2 '+'=3 '-'=4 '.'=5 ','=6 '['=7 ']'=8; others ignored.
//  char_ready = (state==LOAD), combinational from state.
//  pm_addr/pm_data/pm_wren are registered: a write appears the cycle after the
//   accepting edge and is asserted for exactly one cycle.
//  LOAD, on transfer of a command char:
//   - wptr==DEPTH-1 -> no write; err_overflow=1; ERROR.
//   - ']' with depth==0 -> no write; err_bracket=1; ERROR.
//   - '[' with depth==max -> no write; err_bracket=1; ERROR.
//   - else write opcode @wptr; wptr++; '[' depth++; ']' depth--.
//  Non-command chars are consumed (handshake completes) with no write.
//  LOAD, end_in=1 -> TERM. If a transfer happens in the same cycle, the char is
//   processed first. An error from that char wins: ERROR, and end_in is dropped.
//  TERM (1 cycle, char_ready=0): write HALT @wptr; prog_len=wptr.
//   depth!=0 -> err_bracket=1, ERROR; else DONE.
//  DONE: input_done=1 (level), no writes, char_ready=0; char_valid/end_in ignored.
//  ERROR: input_done=0, flags hold, no writes, char_ready=0.
//  restart in DONE/ERROR -> LOAD. It clears wptr, depth, prog_len, err_*, input_done
//   next cycle. restart in LOAD/TERM is ignored.
//  Reset mid-load aborts immediately: outputs go to reset values. pmemory contents
//   are not cleared.
//  wptr is ADDR_W bits and never wraps, because the overflow check precedes increment.
// STRUCTURE
//  bf_opcodes.vh (shared include): opcode localparams OP_HALT..OP_JBK. The control
//   FSM includes it too, so both sides use one encoding.
//  Sub-module bf_char_decode: combinational ASCII -> {is_cmd, opcode[3:0]}.
//  Top: 3-bit state reg (LOAD/TERM/DONE/ERROR), wptr, depth counter, output regs.
// TESTING
//  "+[->+<]." then end_in -> writes 3,7,4,1,3,2,8,5 @0..7, HALT @8; prog_len=8;
//   input_done=1.
//  "a+ b\n-" then end_in -> only 3@0, 4@1, 0@2; comment chars consumed with no pm_wren.
//  "]" -> no write, err_bracket=1, char_ready=0; restart -> LOAD, flags cleared.
//  "[[" then end_in -> writes 7@0, 7@1, HALT@2; err_bracket=1; input_done=0.
//  DEPTH=8: 7 '+' accepted @0..6; 8th '+' -> err_overflow=1, no write.
//  '+' with end_in same cycle -> 3@0, then HALT@1 next cycle; DONE. Reset asserted
//   mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bf_program_loader_pkg.sv
// Shared types for the Brainfuck program loader: the 4-bit opcode encoding
// (common with the control FSM) and the loader state encoding.
package bf_program_loader_pkg;

  typedef enum logic [3:0] {
    OP_HALT = 4'd0,
    OP_INC  = 4'd1,  // '>'
    OP_DEC  = 4'd2,  // '<'
    OP_ADD  = 4'd3,  // '+'
    OP_SUB  = 4'd4,  // '-'
    OP_OUT  = 4'd5,  // '.'
    OP_IN   = 4'd6,  // ','
    OP_JMP  = 4'd7,  // '['
    OP_JBK  = 4'd8   // ']'
  } opcode_e;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_TERM  = 3'd1,
    ST_DONE  = 3'd2,
    ST_ERROR = 3'd3
  } state_e;

  localparam int CHAR_W = 8;

endpackage

// File: rtl/bf_program_loader_if.sv
// Character-source / pmemory-write bundle of the program loader.
// master = the source feeding characters; slave = the loader itself.
interface bf_program_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic              end_in;
  logic              restart;
  logic [ADDR_W-1:0] pm_addr;
  logic [3:0]        pm_data;
  logic              pm_wren;
  logic              input_done;
  logic [ADDR_W-1:0] prog_len;
  logic              err_overflow;
  logic              err_bracket;

  modport master (
    output char_in, char_valid, end_in, restart,
    input  char_ready, pm_addr, pm_data, pm_wren, input_done, prog_len,
           err_overflow, err_bracket
  );

  modport slave (
    input  char_in, char_valid, end_in, restart,
    output char_ready, pm_addr, pm_data, pm_wren, input_done, prog_len,
           err_overflow, err_bracket
  );
endinterface

// File: rtl/bf_program_loader_char_decode.sv
// Combinational ASCII -> opcode decoder; is_cmd_o flags the eight command
// characters, everything else is a comment.
module bf_char_decode
  import bf_program_loader_pkg::*;
(
  input  logic [CHAR_W-1:0] char_i,
  output logic              is_cmd_o,
  output opcode_e           opcode_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    is_cmd_o = 1'b1;
    opcode_o = OP_HALT;
    unique case (char_i)
      8'h3E:   opcode_o = OP_INC;
      8'h3C:   opcode_o = OP_DEC;
      8'h2B:   opcode_o = OP_ADD;
      8'h2D:   opcode_o = OP_SUB;
      8'h2E:   opcode_o = OP_OUT;
      8'h2C:   opcode_o = OP_IN;
      8'h5B:   opcode_o = OP_JMP;
      8'h5D:   opcode_o = OP_JBK;
      default: is_cmd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// Brainfuck program loader: filters and encodes source characters into
// consecutive pmemory words, appends HALT and checks bracket balance.
module bf_program_loader
  import bf_program_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  parameter int NEST_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bf_program_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);
  localparam logic [NEST_W-1:0] MAX_NEST  = {NEST_W{1'b1}};

  state_e            state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [NEST_W-1:0] depth_q;
  logic [ADDR_W-1:0] pm_addr_q;
  logic [3:0]        pm_data_q;
  logic              pm_wren_q;
  logic              input_done_q;
  logic [ADDR_W-1:0] prog_len_q;
  logic              err_overflow_q;
  logic              err_bracket_q;

  logic              is_cmd;
  opcode_e           opcode;
  logic              xfer;

  bf_char_decode u_decode (
    .char_i   (bus.char_in),
    .is_cmd_o (is_cmd),
    .opcode_o (opcode)
  );

  assign xfer = bus.char_valid && (state_q == ST_LOAD);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_LOAD;
      wptr_q         <= '0;
      depth_q        <= '0;
      pm_addr_q      <= '0;
      pm_data_q      <= '0;
      pm_wren_q      <= 1'b0;
      input_done_q   <= 1'b0;
      prog_len_q     <= '0;
      err_overflow_q <= 1'b0;
      err_bracket_q  <= 1'b0;
    end else begin
      pm_wren_q <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          if (xfer && is_cmd) begin
            // A character error takes priority over a coincident end_in.
            if (wptr_q == LAST_SLOT) begin
              err_overflow_q <= 1'b1;
              state_q        <= ST_ERROR;
            end else if ((opcode == OP_JBK && depth_q == '0) ||
                         (opcode == OP_JMP && depth_q == MAX_NEST)) begin
              err_bracket_q <= 1'b1;
              state_q       <= ST_ERROR;
            end else begin
              pm_addr_q <= wptr_q;
              pm_data_q <= opcode;
              pm_wren_q <= 1'b1;
              wptr_q    <= wptr_q + ADDR_W'(1);
              if (opcode == OP_JMP) depth_q <= depth_q + NEST_W'(1);
              if (opcode == OP_JBK) depth_q <= depth_q - NEST_W'(1);
              if (bus.end_in) state_q <= ST_TERM;
            end
          end else if (bus.end_in) begin
            state_q <= ST_TERM;
          end
        end
        ST_TERM: begin
          pm_addr_q  <= wptr_q;
          pm_data_q  <= OP_HALT;
          pm_wren_q  <= 1'b1;
          prog_len_q <= wptr_q;
          if (depth_q != '0) begin
            err_bracket_q <= 1'b1;
            state_q       <= ST_ERROR;
          end else begin
            input_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (bus.restart) begin
            state_q        <= ST_LOAD;
            wptr_q         <= '0;
            depth_q        <= '0;
            prog_len_q     <= '0;
            err_overflow_q <= 1'b0;
            err_bracket_q  <= 1'b0;
            input_done_q   <= 1'b0;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.char_ready   = (state_q == ST_LOAD);
  assign bus.pm_addr      = pm_addr_q;
  assign bus.pm_data      = pm_data_q;
  assign bus.pm_wren      = pm_wren_q;
  assign bus.input_done   = input_done_q;
  assign bus.prog_len     = prog_len_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_bracket  = err_bracket_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Bench for bf_program_loader: a full-size and a tiny (DEPTH=8, NEST_W=2)
// instance share one character stream and are checked against a source-level model.
module tb_bf_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       end_in;
  logic       restart;

  int n_cmp  = 0;
  int n_fail = 0;

  byte src_q[$];
  int  big_wr[$];
  int  small_wr[$];

  bf_program_loader_if #(.ADDR_W(16)) big_if ();
  bf_program_loader_if #(.ADDR_W(16)) small_if ();

  assign big_if.char_in      = char_in;
  assign big_if.char_valid   = char_valid;
  assign big_if.end_in       = end_in;
  assign big_if.restart      = restart;
  assign small_if.char_in    = char_in;
  assign small_if.char_valid = char_valid;
  assign small_if.end_in     = end_in;
  assign small_if.restart    = restart;

  bf_program_loader #(.ADDR_W(16), .DEPTH(65536), .NEST_W(8)) u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (big_if)
  );

  bf_program_loader #(.ADDR_W(16), .DEPTH(8), .NEST_W(2)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (small_if)
  );

  always #5 clk = ~clk;

  // Every pmemory write seen, encoded as addr*16 + opcode.
  always @(negedge clk) begin
    if (big_if.pm_wren === 1'b1)
      big_wr.push_back(int'(big_if.pm_addr) * 16 + int'(big_if.pm_data));
    if (small_if.pm_wren === 1'b1)
      small_wr.push_back(int'(small_if.pm_addr) * 16 + int'(small_if.pm_data));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Source-level model: walk the characters, keep commands, track nesting.
  function automatic void model(input int depth, input int max_nest, output int wr[$],
                                output int plen, output bit done, output bit ovf,
                                output bit br);
    string cmds = "><+-.,[]";
    int pos = 0;
    int nest = 0;
    int op;
    wr.delete();
    plen = 0; done = 0; ovf = 0; br = 0;
    for (int i = 0; i < src_q.size(); i++) begin
      if (ovf || br) break;
      op = 0;
      for (int k = 0; k < 8; k++) if (src_q[i] == cmds[k]) op = k + 1;
      if (op == 0) continue;
      if (pos == depth - 1) ovf = 1;
      else if (op == 8 && nest == 0) br = 1;
      else if (op == 7 && nest == max_nest) br = 1;
      else begin
        wr.push_back(pos * 16 + op);
        pos++;
        if (op == 7) nest++;
        if (op == 8) nest--;
      end
    end
    if (!ovf && !br) begin
      wr.push_back(pos * 16);
      plen = pos;
      if (nest != 0) br = 1;
      else done = 1;
    end
  endfunction

  task automatic check_result(input string who, input int got[$], input int exp[$],
                              input int plen_o, input int plen_e, input bit done_o,
                              input bit done_e, input bit ovf_o, input bit ovf_e,
                              input bit br_o, input bit br_e, input bit rdy_o);
    check({who, " write_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check($sformatf("%s write[%0d] addr*16+op", who, i), got[i], exp[i]);
    check({who, " prog_len"}, plen_o, plen_e);
    check({who, " input_done"}, done_o, done_e);
    check({who, " err_overflow"}, ovf_o, ovf_e);
    check({who, " err_bracket"}, br_o, br_e);
    check({who, " char_ready_after_end"}, rdy_o, 1'b0);
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check("big restart char_ready", big_if.char_ready, 1'b1);
    check("big restart flags/done/len",
          {big_if.err_overflow, big_if.err_bracket, big_if.input_done, big_if.prog_len}, '0);
    check("small restart char_ready", small_if.char_ready, 1'b1);
    check("small restart flags/done/len",
          {small_if.err_overflow, small_if.err_bracket, small_if.input_done, small_if.prog_len}, '0);
  endtask

  // Stream src_q back to back, then end_in (with the last char if end_last).
  task automatic run(input bit end_last);
    int  ew[$];
    int  plen;
    bit  done, ovf, br;
    @(negedge clk);
    big_wr.delete();
    small_wr.delete();
    for (int i = 0; i < src_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      char_in    = src_q[i];
      char_valid = 1'b1;
      end_in     = end_last && (i == src_q.size() - 1);
    end
    if (!end_last || src_q.size() == 0) begin
      if (src_q.size() > 0) @(negedge clk);
      char_valid = 1'b0;
      end_in     = 1'b1;
    end
    @(negedge clk);
    char_valid = 1'b0;
    end_in     = 1'b0;
    repeat (3) @(negedge clk);
    model(65536, 255, ew, plen, done, ovf, br);
    check_result("big", big_wr, ew, int'(big_if.prog_len), plen, big_if.input_done, done,
                 big_if.err_overflow, ovf, big_if.err_bracket, br, big_if.char_ready);
    model(8, 3, ew, plen, done, ovf, br);
    check_result("small", small_wr, ew, int'(small_if.prog_len), plen, small_if.input_done, done,
                 small_if.err_overflow, ovf, small_if.err_bracket, br, small_if.char_ready);
    do_restart();
  endtask

  task automatic load_str(input string s);
    src_q.delete();
    for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
  endtask

  task automatic gen_random(input bit balanced);
    string alpha = "+-<>.,[]a \n";
    int    open = 0;
    int    n;
    byte   c;
    src_q.delete();
    n = $urandom_range(0, 20);
    for (int i = 0; i < n; i++) begin
      c = alpha[$urandom_range(0, 10)];
      if (balanced && c == 8'h5D && open == 0) c = 8'h2B;
      if (c == 8'h5B) open++;
      if (c == 8'h5D && open > 0) open--;
      src_q.push_back(c);
    end
    if (balanced) while (open > 0) begin src_q.push_back(8'h5D); open--; end
  endtask

  initial begin
    rst_n = 1'b0; char_in = '0; char_valid = 1'b0; end_in = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk);
    check("reset pm_wren", big_if.pm_wren, 1'b0);
    check("reset pm_addr/pm_data", {big_if.pm_addr, big_if.pm_data}, '0);
    check("reset done/len/flags",
          {big_if.input_done, big_if.prog_len, big_if.err_overflow, big_if.err_bracket}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset char_ready", big_if.char_ready, 1'b1);

    // '+' together with end_in: write next cycle, HALT the cycle after, then DONE.
    char_in = 8'h2B; char_valid = 1'b1; end_in = 1'b1;
    @(negedge clk);
    char_valid = 1'b0; end_in = 1'b0;
    check("plus+end first write", {big_if.pm_wren, big_if.pm_addr, big_if.pm_data}, {1'b1, 16'd0, 4'd3});
    check("plus+end TERM char_ready", big_if.char_ready, 1'b0);
    @(negedge clk);
    check("plus+end HALT write", {big_if.pm_wren, big_if.pm_addr, big_if.pm_data}, {1'b1, 16'd1, 4'd0});
    @(negedge clk);
    check("plus+end single-cycle wren", big_if.pm_wren, 1'b0);
    check("plus+end input_done", big_if.input_done, 1'b1);
    check("plus+end prog_len", big_if.prog_len, 16'd1);
    do_restart();

    load_str("+[->+<].");   run(1'b0);
    load_str("a+ b\n-");    run(1'b0);
    load_str("]");          run(1'b0);
    load_str("[[");         run(1'b0);
    load_str("+++++++");    run(1'b0);
    load_str("++++++++");   run(1'b1);
    load_str("[[[]]]");     run(1'b0);
    load_str("[[[[]]]]");   run(1'b0);
    load_str("x]");         run(1'b1);
    for (int r = 0; r < 12; r++) begin
      gen_random(r[0]);
      run(r[1]);
    end

    // Asynchronous reset mid-stream, while a write is on the bus.
    @(negedge clk);
    char_in = 8'h2B; char_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset pm_wren", {big_if.pm_wren, small_if.pm_wren}, 2'b00);
    check("async reset pm_addr/pm_data", {big_if.pm_addr, big_if.pm_data}, '0);
    char_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release char_ready", big_if.char_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
